// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : In-order pipeline RAW scoreboard producing stall and forwarding
//               selects for the decode stage, plus a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int READY_ALU  = 1,
    parameter int READY_LOAD = 2,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16,
    localparam int FW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_uses_rs1,
    input  logic             dec_uses_rs2,
    input  logic [4:0]       dec_rd,
    input  logic             dec_wr,
    input  logic             dec_is_load,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             stall,
    output logic [FW-1:0]    fwd_a,
    output logic [FW-1:0]    fwd_b,
    output logic [FW-1:0]    inflight,
    output logic [CNT_W-1:0] stall_cnt
);

    // Entry k describes the instruction currently in pipeline stage k.
    logic [DEPTH:1]      r_valid;
    logic [DEPTH:1][4:0] r_rd;
    logic [DEPTH:1]      r_load;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_haz_a;
    logic                w_haz_b;
    logic [FW-1:0]       w_fwd_a;
    logic [FW-1:0]       w_fwd_b;
    logic                w_stall;
    logic                w_issue;
    logic [FW-1:0]       w_inflight;

    // Returns {hazard, forward_stage}; the downward scan lets the youngest match win.
    function automatic logic [FW:0] resolve(
        input logic                uses,
        input logic [4:0]          addr,
        input logic [DEPTH:1]      v,
        input logic [DEPTH:1][4:0] rd,
        input logic [DEPTH:1]      ld
    );
        logic          found;
        logic          is_ld;
        logic          ready;
        logic [FW-1:0] stage;
        logic [FW:0]   res;
        found = 1'b0;
        is_ld = 1'b0;
        stage = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (uses && (addr != 5'd0) && v[k] && (rd[k] == addr)) begin
                found = 1'b1;
                stage = FW'(k);
                is_ld = ld[k];
            end
        end
        ready = is_ld ? (int'(stage) >= READY_LOAD) : (int'(stage) >= READY_ALU);
        if (!found) begin
            res = '0;
        end else if ((FWD_EN != 0) && ready) begin
            res = {1'b0, stage};
        end else begin
            res = {1'b1, {FW{1'b0}}};
        end
        return res;
    endfunction

    always_comb begin
        {w_haz_a, w_fwd_a} = resolve(dec_uses_rs1, dec_rs1, r_valid, r_rd, r_load);
        {w_haz_b, w_fwd_b} = resolve(dec_uses_rs2, dec_rs2, r_valid, r_rd, r_load);
    end

    assign w_stall = dec_valid & ~flush & (w_haz_a | w_haz_b);
    assign w_issue = dec_valid & dec_wr & ~w_stall & ~flush & (dec_rd != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_rd    <= '0;
            r_load  <= '0;
        end else begin
            r_valid <= {r_valid[DEPTH-1:1], w_issue};
            r_rd    <= {r_rd[DEPTH-1:1], dec_rd};
            r_load  <= {r_load[DEPTH-1:1], dec_is_load};
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            w_inflight = w_inflight + {{(FW-1){1'b0}}, r_valid[k]};
        end
    end

    // Clear wins over increment; increment stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall     = w_stall;
    assign fwd_a     = w_fwd_a;
    assign fwd_b     = w_fwd_b;
    assign inflight  = w_inflight;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// Testbench for hazard_scoreboard: directed vector table on the default build,
// directed corner sequences, and random stimulus against a reference model.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       dec_valid;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_uses_rs1, dec_uses_rs2, dec_wr, dec_is_load, flush, cnt_clr;

    logic        stall1, stall2;
    logic [1:0]  fa1, fb1, inf1, fa2, fb2, inf2;
    logic [15:0] cnt1;
    logic [3:0]  cnt2;

    int n_cmp = 0;
    int n_err = 0;

    hazard_scoreboard u_dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
        .dec_rd(dec_rd), .dec_wr(dec_wr), .dec_is_load(dec_is_load),
        .flush(flush), .cnt_clr(cnt_clr),
        .stall(stall1), .fwd_a(fa1), .fwd_b(fb1), .inflight(inf1), .stall_cnt(cnt1)
    );

    hazard_scoreboard #(.FWD_EN(0), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
        .dec_rd(dec_rd), .dec_wr(dec_wr), .dec_is_load(dec_is_load),
        .flush(flush), .cnt_clr(cnt_clr),
        .stall(stall2), .fwd_a(fa2), .fwd_b(fb2), .inflight(inf2), .stall_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int v, rs1, rs2, u1, u2, rd, wr, ld, fl;
        int e_st, e_fa, e_fb, e_inf;
    } vec_t;
    vec_t tbl [28];

    // Reference model: per build, what occupies stages 1..3 (index 0 = default, 1 = no-forward)
    int m_v  [2][4];
    int m_rd [2][4];
    int m_ld [2][4];
    int m_cnt[2];
    int m_st [2];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input int v, input int rs1, input int rs2, input int u1, input int u2,
                       input int rd, input int wr, input int ld, input int fl, input int clr);
        dec_valid    = (v != 0);
        dec_rs1      = 5'(rs1);
        dec_rs2      = 5'(rs2);
        dec_uses_rs1 = (u1 != 0);
        dec_uses_rs2 = (u2 != 0);
        dec_rd       = 5'(rd);
        dec_wr       = (wr != 0);
        dec_is_load  = (ld != 0);
        flush        = (fl != 0);
        cnt_clr      = (clr != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_clear();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                m_v[i][k] = 0; m_rd[i][k] = 0; m_ld[i][k] = 0;
            end
            m_cnt[i] = 0;
            m_st[i]  = 0;
        end
    endfunction

    function automatic void m_src(input int i, input int uses, input int addr,
                                  output int haz, output int fwd);
        int need;
        haz = 0;
        fwd = 0;
        if (uses == 0 || addr == 0) return;
        for (int k = 1; k <= 3; k++) begin
            if (m_v[i][k] != 0 && m_rd[i][k] == addr) begin
                need = (m_ld[i][k] != 0) ? 2 : 1;
                if (i == 0 && k >= need) fwd = k;
                else haz = 1;
                return;
            end
        end
    endfunction

    function automatic void m_eval(input int i, output int st, output int fa,
                                   output int fb, output int inf);
        int ha, hb;
        m_src(i, int'(dec_uses_rs1), int'(dec_rs1), ha, fa);
        m_src(i, int'(dec_uses_rs2), int'(dec_rs2), hb, fb);
        st  = (dec_valid && !flush && (ha != 0 || hb != 0)) ? 1 : 0;
        inf = 0;
        for (int k = 1; k <= 3; k++) inf += m_v[i][k];
    endfunction

    function automatic void m_step(input int i);
        int maxc;
        maxc = (i == 0) ? 65535 : 15;
        for (int k = 3; k >= 2; k--) begin
            m_v[i][k] = m_v[i][k-1]; m_rd[i][k] = m_rd[i][k-1]; m_ld[i][k] = m_ld[i][k-1];
        end
        m_v[i][1]  = (dec_valid && dec_wr && m_st[i] == 0 && !flush && dec_rd != 0) ? 1 : 0;
        m_rd[i][1] = int'(dec_rd);
        m_ld[i][1] = int'(dec_is_load);
        if (cnt_clr) m_cnt[i] = 0;
        else if (m_st[i] != 0 && m_cnt[i] < maxc) m_cnt[i]++;
    endfunction

    task automatic reset_pulse();
        @(negedge clk);
        #1 rst_n = 1'b0;
        m_clear();
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int st, fa, fb, inf;
        //          v rs1 rs2 u1 u2 rd wr ld fl | st fa fb inf
        tbl[0]  = '{1, 0, 0, 0, 0, 5, 1, 0, 0,   0, 0, 0, 0};
        tbl[1]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 1};
        tbl[2]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0,   0, 2, 0, 1};
        tbl[3]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0,   0, 3, 0, 1};
        tbl[4]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 6, 1, 1, 0,   0, 0, 0, 0};
        tbl[6]  = '{1, 0, 6, 0, 1, 0, 0, 0, 0,   1, 0, 0, 1};
        tbl[7]  = '{1, 0, 6, 0, 1, 0, 0, 0, 0,   0, 0, 2, 1};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1};
        tbl[9]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0,   0, 0, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 7, 1, 0, 0,   0, 0, 0, 1};
        tbl[11] = '{1, 7, 7, 1, 1, 0, 0, 0, 0,   0, 1, 1, 2};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0};
        tbl[15] = '{1, 0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0};
        tbl[16] = '{1, 0, 0, 0, 0, 9, 1, 0, 0,   0, 0, 0, 0};
        tbl[17] = '{1, 9, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1};
        tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1};
        tbl[19] = '{1, 0, 0, 0, 0,10, 1, 1, 0,   0, 0, 0, 1};
        tbl[20] = '{1,10, 0, 1, 0,11, 1, 0, 1,   0, 0, 0, 1};
        tbl[21] = '{1,10, 0, 1, 0, 0, 0, 0, 0,   0, 2, 0, 1};
        tbl[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1};
        tbl[23] = '{1, 0, 0, 0, 0,12, 1, 1, 0,   0, 0, 0, 0};
        tbl[24] = '{0,12, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1};
        tbl[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1};
        tbl[26] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1};
        tbl[27] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0};

        // Reset state, with a live hazard-shaped input applied
        rst_n = 1'b0;
        drv(1, 5, 5, 1, 1, 5, 1, 1, 0, 0);
        m_clear();
        #12;
        chk("rst_stall", int'(stall1), 0);
        chk("rst_fwd_a", int'(fa1), 0);
        chk("rst_fwd_b", int'(fb1), 0);
        chk("rst_inflight", int'(inf1), 0);
        chk("rst_cnt", int'(cnt1), 0);
        chk("rst_stall2", int'(stall2), 0);
        chk("rst_inflight2", int'(inf2), 0);
        chk("rst_cnt2", int'(cnt2), 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        tick();

        // Directed vector table, default build
        for (int r = 0; r < 28; r++) begin
            drv(tbl[r].v, tbl[r].rs1, tbl[r].rs2, tbl[r].u1, tbl[r].u2,
                tbl[r].rd, tbl[r].wr, tbl[r].ld, tbl[r].fl, 0);
            @(negedge clk);
            chk($sformatf("tbl%0d_stall", r), int'(stall1), tbl[r].e_st);
            chk($sformatf("tbl%0d_fwd_a", r), int'(fa1), tbl[r].e_fa);
            chk($sformatf("tbl%0d_fwd_b", r), int'(fb1), tbl[r].e_fb);
            chk($sformatf("tbl%0d_inflight", r), int'(inf1), tbl[r].e_inf);
            tick();
        end
        chk("load_use_cnt", int'(cnt1), 1);

        // Clear coinciding with a stall cycle
        drv(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
        tick();
        drv(1, 0, 6, 0, 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("clr_stall", int'(stall1), 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("clr_cnt", int'(cnt1), 0);
        tick();

        // No-forward build: every match stalls until the writer retires
        reset_pulse();
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        tick();
        drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("nofwd_stall%0d", c), int'(stall2), 1);
            chk($sformatf("nofwd_fa%0d", c), int'(fa2), 0);
            tick();
        end
        @(negedge clk);
        chk("nofwd_release", int'(stall2), 0);
        chk("nofwd_fa_rel", int'(fa2), 0);
        chk("nofwd_cnt", int'(cnt2), 3);
        tick();
        for (int n = 0; n < 6; n++) begin
            drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
            tick();
            drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
            repeat (4) tick();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat_cnt", int'(cnt2), 15);
        tick();
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        tick();
        drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("sat_clr_stall", int'(stall2), 1);
        tick();
        drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat_clr_cnt", int'(cnt2), 0);
        tick();

        // Random stimulus, both builds against the model
        reset_pulse();
        for (int n = 0; n < 1500; n++) begin
            drv(($urandom % 4) != 0 ? 1 : 0,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)),
                ($urandom % 8) == 0 ? 1 : 0, ($urandom % 64) == 0 ? 1 : 0);
            @(negedge clk);
            m_eval(0, st, fa, fb, inf);
            m_st[0] = st;
            chk("rnd_stall", int'(stall1), st);
            chk("rnd_fwd_a", int'(fa1), fa);
            chk("rnd_fwd_b", int'(fb1), fb);
            chk("rnd_inflight", int'(inf1), inf);
            chk("rnd_cnt", int'(cnt1), m_cnt[0]);
            m_eval(1, st, fa, fb, inf);
            m_st[1] = st;
            chk("rnd2_stall", int'(stall2), st);
            chk("rnd2_fwd_a", int'(fa2), fa);
            chk("rnd2_fwd_b", int'(fb2), fb);
            chk("rnd2_inflight", int'(inf2), inf);
            chk("rnd2_cnt", int'(cnt2), m_cnt[1]);
            @(posedge clk);
            m_step(0);
            m_step(1);
            #1;
        end

        // Asynchronous reset in the middle of a stall
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        drv(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
        tick();
        drv(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
        tick();
        drv(1, 6, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_stall", int'(stall1), 1);
        chk("mid_inflight", int'(inf1), 2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", int'(stall1), 0);
        chk("mid_rst_inflight", int'(inf1), 0);
        chk("mid_rst_cnt", int'(cnt1), 0);
        chk("mid_rst_fwd_a", int'(fa1), 0);
        chk("mid_rst_stall2", int'(stall2), 0);
        #2 rst_n = 1'b1;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3: in-flight stages tracked after decode (1=EX, 2=MEM, 3=WB); legal range 2..7.
REQ-002 SHALL have parameter READY_ALU, default 1: first stage index where a non-load result can be forwarded.
REQ-003 SHALL have parameter READY_LOAD, default 2: first stage index where a load result can be forwarded; READY_ALU <= READY_LOAD <= DEPTH.
REQ-004 SHALL have parameter FWD_EN, default 1: 1 enables forwarding; 0 makes every hazard stall.
REQ-005 SHALL have parameter CNT_W, default 16: width of the stall performance counter.
REQ-006 SHALL define FW = $clog2(DEPTH+1) as the forward-select width.
REQ-007 CLK  input  1  single clock; all state updates on its rising edge.
REQ-008 RST  input  1  reset, asynchronous and active-low.
REQ-009 DEC_VALID  input  1  decode slot holds a valid instruction.
REQ-010 DEC_RS1, DEC_RS2  input  5 each  source register addresses.
REQ-011 DEC_USES_RS1, DEC_USES_RS2  input  1 each  the instruction reads that source.
REQ-012 DEC_RD  input  5  destination register address.
REQ-013 DEC_WR  input  1  the instruction writes DEC_RD.
REQ-014 DEC_IS_LOAD  input  1  the instruction is a load.
REQ-015 FLUSH  input  1  squash the decode instruction (taken branch or jump).
REQ-016 CNT_CLR  input  1  synchronous clear of STALL_CNT.
REQ-017 STALL  output  1  hold PC and decode registers; insert a bubble into stage 1.
REQ-018 FWD_A, FWD_B  output  FW each  operand source: 0 = register file, k = stage k result.
REQ-019 INFLIGHT  output  FW  count of valid scoreboard entries.
REQ-020 STALL_CNT  output  CNT_W  saturating count of stall cycles.

Function
REQ-021 SHALL hold DEPTH entries; each entry has {valid, rd[4:0], is_load}.
REQ-022 Every cycle, entry k+1 SHALL load entry k, and entry DEPTH SHALL be discarded.
REQ-023 Entry 1 SHALL load {1, DEC_RD, DEC_IS_LOAD} only when DEC_VALID & DEC_WR & !STALL & !FLUSH & DEC_RD != 0; otherwise entry 1 SHALL load valid = 0.
REQ-024 A source SHALL match entry k when the source's USES bit is 1, the address is non-zero, entry k is valid and entry k rd equals the address.
REQ-025 Each source SHALL resolve against the youngest (lowest k) matching entry only.
REQ-026 A match at stage k SHALL be ready when k >= (is_load ? READY_LOAD : READY_ALU).
REQ-027 With FWD_EN=1: ready youngest match gives FWD = k; not-ready youngest match raises the hazard and gives FWD = 0.
REQ-028 With FWD_EN=0: any match raises the hazard, and FWD_A and FWD_B SHALL be 0 always.
REQ-029 If no entry matches a source, its FWD SHALL be 0.
REQ-030 STALL = DEC_VALID & !FLUSH & (hazard on RS1 | hazard on RS2).
REQ-031 STALL, FWD_A and FWD_B SHALL be combinational from the current inputs and scoreboard state, with zero-cycle latency.
REQ-032 When FLUSH=1, STALL SHALL be 0 and a bubble SHALL enter entry 1, regardless of any hazard.
REQ-033 INFLIGHT SHALL equal the population count of valid entries.
REQ-034 STALL_CNT SHALL increment on each cycle with STALL=1 and saturate at all-ones.
REQ-035 When CNT_CLR=1, STALL_CNT SHALL load 0, with priority over increment.
REQ-036 A stalled instruction SHALL re-evaluate every cycle; STALL SHALL drop in the first cycle its blocking entry becomes ready or retires.

Reset
REQ-037 While RST=0, all entries SHALL be invalid and STALL_CNT SHALL be 0, asynchronously.
REQ-038 Consequently, during reset STALL=0, FWD_A=FWD_B=0 and INFLIGHT=0.
REQ-039 Reset asserted mid-stall SHALL drop STALL immediately, without waiting for a clock edge.
REQ-040 Operation SHALL resume on the first rising CLK edge after RST returns to 1.

Verification (defaults: DEPTH=3, READY_ALU=1, READY_LOAD=2, FWD_EN=1)
REQ-041 Issue add x5, then decode reads x5 on RS1 -> FWD_A=1, STALL=0; one cycle later a reader of x5 gets FWD_A=2, the next cycle FWD_A=3, then 0.
REQ-042 Issue lw x6, then decode reads x6 on RS2 -> STALL=1 for 1 cycle, then FWD_B=2, STALL=0; STALL_CNT=1.
REQ-043 Entries 1 and 2 both hold rd=x7, decode reads x7 on both sources -> FWD_A=FWD_B=1, STALL=0.
REQ-044 Issue write to x0, then read x0 -> INFLIGHT unchanged, FWD=0, STALL=0.
REQ-045 FLUSH=1 with a load-use hazard pending -> STALL=0 and entry 1 becomes a bubble; with FWD_EN=0, add x5 then read x5 -> STALL for 3 cycles, then FWD_A=0 and STALL_CNT=3.
REQ-046 RST=0 mid-stall with INFLIGHT=2 -> STALL=0 and INFLIGHT=0 before the next edge, STALL_CNT=0; counter saturation at 0xFFFF holds; CNT_CLR=1 together with a stall gives 0.
